// File: rtl/bsg_front_side_bus_hop_in_mcast.sv
// FSB ingress hop: buffers words in a small FIFO and delivers each to the channels named by its destination mask.
// Optional BSG_FSB_HOP_IN_MCAST_STATS_EN adds drop_count_o, a saturating count of retired zero-mask words.
module bsg_front_side_bus_hop_in_mcast #(
  parameter int width_p   = 16,
  parameter int fan_out_p = 5,
  parameter int els_p     = 2
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  output logic                           ready_o,
  input  logic                           v_i,
  input  logic [width_p-1:0]             data_i,
  input  logic [fan_out_p-1:0]           dest_mask_i,
  output logic [fan_out_p-1:0]           v_o,
  output logic [fan_out_p*width_p-1:0]   data_o,
  input  logic [fan_out_p-1:0]           ready_i
`ifdef BSG_FSB_HOP_IN_MCAST_STATS_EN
  ,
  output logic [15:0]                    drop_count_o
`endif
);

  localparam int ptr_w   = $clog2(els_p);
  localparam int cnt_w   = ptr_w + 1;
  localparam int entry_w = width_p + fan_out_p;

  logic [entry_w-1:0]   mem_reg [els_p];
  logic [ptr_w-1:0]     rd_ptr_reg, wr_ptr_reg;
  logic [cnt_w-1:0]     count_reg, count_next;
  logic [fan_out_p-1:0] sent_reg, sent_next;

  logic [width_p-1:0]   head_data;
  logic [fan_out_p-1:0] head_mask;
  logic [fan_out_p-1:0] fire, done;
  logic                 empty, enq, deq;

  assign empty     = (count_reg == '0);
  // Reset gates ready so nothing is accepted while the FIFO is being cleared.
  assign ready_o   = ~reset_i & (count_reg != cnt_w'(els_p));
  assign enq       = v_i & ready_o;
  assign head_data = mem_reg[rd_ptr_reg][entry_w-1:fan_out_p];
  assign head_mask = mem_reg[rd_ptr_reg][fan_out_p-1:0];

  assign v_o  = {fan_out_p{~empty}} & head_mask & ~sent_reg;
  assign fire = v_o & ready_i;
  assign done = sent_reg | fire | ~head_mask;
  assign deq  = ~empty & (&done);

  genvar gi;
  generate
    for (gi = 0; gi < fan_out_p; gi++) begin : g_data
      assign data_o[gi*width_p +: width_p] = head_data;
    end
  endgenerate

  always_comb begin
    count_next = count_reg;
    if (enq && !deq)      count_next = count_reg + cnt_w'(1);
    else if (!enq && deq) count_next = count_reg - cnt_w'(1);
    sent_next = deq ? '0 : (sent_reg | fire);
  end

  always_ff @(posedge clk_i) begin
    if (enq) mem_reg[wr_ptr_reg] <= {data_i, dest_mask_i};
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
      sent_reg   <= '0;
    end else begin
      if (enq) wr_ptr_reg <= wr_ptr_reg + ptr_w'(1);
      if (deq) rd_ptr_reg <= rd_ptr_reg + ptr_w'(1);
      count_reg <= count_next;
      sent_reg  <= sent_next;
    end
  end

`ifdef BSG_FSB_HOP_IN_MCAST_STATS_EN
  logic [15:0] drop_count_reg;
  assign drop_count_o = drop_count_reg;

  always_ff @(posedge clk_i) begin
    if (reset_i)
      drop_count_reg <= '0;
    else if (deq && (head_mask == '0) && (drop_count_reg != 16'hFFFF))
      drop_count_reg <= drop_count_reg + 16'd1;
  end
`endif

endmodule

// File: tb/tb_bsg_front_side_bus_hop_in_mcast.sv
// Scoreboard bench for the multicast FSB input hop: per-channel expected-data queues filled on enqueue, drained by a monitor.
module tb_bsg_front_side_bus_hop_in_mcast;
  localparam int W = 16;
  localparam int F = 5;
  localparam int E = 2;

  logic           clk = 1'b0;
  logic           reset_i;
  logic           ready_o;
  logic           v_i;
  logic [W-1:0]   data_i;
  logic [F-1:0]   dest_mask_i;
  logic [F-1:0]   v_o;
  logic [F*W-1:0] data_o;
  logic [F-1:0]   ready_i;
`ifdef BSG_FSB_HOP_IN_MCAST_STATS_EN
  logic [15:0]    drop_count_o;
`endif

  int checks   = 0;
  int failures = 0;
  logic [W-1:0] exp_q [F][$];

  always #5 clk = ~clk;

  bsg_front_side_bus_hop_in_mcast #(.width_p(W), .fan_out_p(F), .els_p(E)) dut (
    .clk_i(clk),
    .reset_i(reset_i),
    .ready_o(ready_o),
    .v_i(v_i),
    .data_i(data_i),
    .dest_mask_i(dest_mask_i),
    .v_o(v_o),
    .data_o(data_o),
    .ready_i(ready_i)
`ifdef BSG_FSB_HOP_IN_MCAST_STATS_EN
    ,
    .drop_count_o(drop_count_o)
`endif
  );

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end else
      $display("ok   %s = %0h", name, got);
  endtask

  // Advance to just after the next rising edge, where inputs are driven.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle of input and sample at the falling edge; record accepted words.
  task automatic drive(input logic v, input logic [W-1:0] d, input logic [F-1:0] m);
    v_i = v; data_i = d; dest_mask_i = m;
    @(negedge clk);
    if (v && ready_o) begin
      for (int i = 0; i < F; i++)
        if (m[i]) exp_q[i].push_back(d);
      $display("enq  data=%h mask=%b", d, m);
    end
  endtask

  task automatic flush();
    for (int i = 0; i < F; i++) exp_q[i].delete();
  endtask

  // Monitor: any asserted channel valid must match that channel's next expected word.
  always @(negedge clk) begin
    if (reset_i === 1'b0) begin
      for (int i = 0; i < F; i++) begin
        if (v_o[i]) begin
          checks++;
          if (exp_q[i].size() == 0) begin
            failures++;
            $display("FAIL mon_unexpected ch=%0d got=v_o=1 data=%h exp=no_word", i, data_o[i*W +: W]);
          end else if (data_o[i*W +: W] !== exp_q[i][0]) begin
            failures++;
            $display("FAIL mon_data ch=%0d got=%h exp=%h", i, data_o[i*W +: W], exp_q[i][0]);
          end else if (ready_i[i]) begin
            $display("dlv  ch=%0d data=%h", i, exp_q[i][0]);
            void'(exp_q[i].pop_front());
          end
        end
      end
    end
  end

  logic [F-1:0] masks [6] = '{5'b10110, 5'b01001, 5'b11111, 5'b00000, 5'b00011, 5'b10000};
  logic [F-1:0] rdys  [8] = '{5'b00000, 5'b10101, 5'b01010, 5'b11111, 5'b00110, 5'b11001, 5'b00000, 5'b01111};

  initial begin
    int k;
    int tries;
    logic acc;
    reset_i = 1'b1; v_i = 1'b0; data_i = '0; dest_mask_i = '0; ready_i = '0;
    cyc(); cyc();
    @(negedge clk);
    chk("reset_ready", ready_o, 0);
    chk("reset_v_o", v_o, 0);
    cyc();
    reset_i = 1'b0;
    @(negedge clk);
    chk("post_reset_ready", ready_o, 1);
    chk("post_reset_v_o", v_o, 0);
    cyc();

    // Broadcast to all channels, retires in its first cycle at the head.
    ready_i = '1;
    drive(1, 16'hA5A5, 5'b11111); chk("t1_accept", ready_o, 1); cyc();
    drive(0, 0, 0);
    chk("t1_v_o", v_o, 5'b11111);
    chk("t1_data_o", data_o, {5{16'hA5A5}});
    chk("t1_ready", ready_o, 1);
    cyc();
    drive(0, 0, 0); chk("t1_retired", v_o, 0); cyc();

    // Partial delivery; channel 0 must not re-assert.
    ready_i = 5'b00001;
    drive(1, 16'h1234, 5'b00101); cyc();
    drive(0, 0, 0); chk("t2_c1_v_o", v_o, 5'b00101); cyc();
    drive(0, 0, 0); chk("t2_c2_v_o", v_o, 5'b00100); cyc();
    drive(0, 0, 0); chk("t2_c3_v_o", v_o, 5'b00100); cyc();
    ready_i = 5'b00100;
    drive(0, 0, 0); chk("t2_c4_v_o", v_o, 5'b00100); cyc();
    drive(0, 0, 0); chk("t2_retired", v_o, 0); cyc();

    // Fill to capacity; third word rejected, then in-order drain.
    ready_i = '0;
    drive(1, 16'h0001, 5'b11111); chk("t3_acc0", ready_o, 1); cyc();
    drive(1, 16'h0002, 5'b11111); chk("t3_acc1", ready_o, 1); cyc();
    drive(1, 16'h0003, 5'b11111); chk("t3_full", ready_o, 0); cyc();
    ready_i = '1;
    drive(0, 0, 0); chk("t3_d0", data_o[W-1:0], 16'h0001); chk("t3_full_hold", ready_o, 0); cyc();
    drive(0, 0, 0); chk("t3_d1", data_o[W-1:0], 16'h0002); chk("t3_d1_v", v_o, 5'b11111); cyc();
    drive(0, 0, 0); chk("t3_empty", v_o, 0); cyc();

    // Zero-mask word between two channel-1 words.
    drive(1, 16'hB001, 5'b00010); cyc();
    drive(1, 16'hB002, 5'b00000); chk("t4_x_v_o", v_o, 5'b00010); cyc();
    drive(1, 16'hB003, 5'b00010); chk("t4_zero_v_o", v_o, 0);
`ifdef BSG_FSB_HOP_IN_MCAST_STATS_EN
    chk("t4_drop_before", drop_count_o, 0);
`endif
    cyc();
    drive(0, 0, 0); chk("t4_z_v_o", v_o, 5'b00010);
`ifdef BSG_FSB_HOP_IN_MCAST_STATS_EN
    chk("t4_drop_after", drop_count_o, 1);
`endif
    cyc();
    drive(0, 0, 0); chk("t4_empty", v_o, 0); cyc();

    // Reset after channel 2 fired, before channel 0 accepts.
    ready_i = 5'b00100;
    drive(1, 16'hC0DE, 5'b00101); cyc();
    drive(0, 0, 0); chk("t5_v_o", v_o, 5'b00101); cyc();
    drive(0, 0, 0); chk("t5_partial", v_o, 5'b00001); cyc();
    reset_i = 1'b1; ready_i = '0;
    @(negedge clk);
    chk("t5_reset_ready", ready_o, 0);
    flush();
    cyc();
    reset_i = 1'b0;
    @(negedge clk);
    chk("t5_after_v_o", v_o, 0);
    chk("t5_after_ready", ready_o, 1);
    cyc();
    ready_i = 5'b00100;
    drive(1, 16'hD00D, 5'b00100); cyc();
    drive(0, 0, 0); chk("t5_redeliver", v_o, 5'b00100); cyc();
    drive(0, 0, 0); chk("t5_done", v_o, 0); cyc();

    // Mixed masks under varying backpressure; monitor checks order and exclusivity.
    k = 0;
    for (int w = 0; w < 6; w++) begin
      tries = 0;
      acc = 1'b0;
      while (!acc && tries < 20) begin
        ready_i = rdys[k % 8];
        drive(1, 16'hE000 + 16'(w), masks[w]);
        acc = ready_o;
        cyc();
        k++;
        tries++;
      end
      chk("t6_accept", acc, 1);
    end
    ready_i = '1;
    for (int c = 0; c < 12; c++) begin
      drive(0, 0, 0);
      cyc();
    end
    for (int i = 0; i < F; i++) chk("t6_drained", 128'(exp_q[i].size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
